dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_port_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Shared data-memory port: arbitrates CPU and loader requests, registers the winning
// command, drives the memory for one cycle and returns read data to its owner.
module dmem_port_arbiter #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   output logic                     cpu_gnt,
   output logic                     cpu_stall,
   output logic [DATA_WIDTH-1:0]    cpu_rdata,
   output logic                     cpu_rvalid,
   input  logic                     ld_req,
   input  logic                     ld_we,
   input  logic [ADDRESS_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0]    ld_wdata,
   output logic                     ld_gnt,
   output logic [DATA_WIDTH-1:0]    ld_rdata,
   output logic                     ld_rvalid,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     mem_we,
   input  logic [DATA_WIDTH-1:0]    mem_rdata
);

   localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
   localparam logic       OWNER_CPU = 1'b0;
   localparam logic       OWNER_LD  = 1'b1;

   logic [3:0]               starve_cnt;
   logic                     cmd_valid;
   logic                     cmd_owner;
   logic                     cmd_we;
   logic [ADDRESS_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0]    cmd_wdata;
   logic                     read_done;

   // Grants are held low during reset so nothing is accepted before the first edge after release.
   assign ld_gnt    = rst_n & ld_req & (~cpu_req | (starve_cnt == LIMIT));
   assign cpu_gnt   = rst_n & cpu_req & ~ld_gnt;
   assign cpu_stall = cpu_req & ~cpu_gnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!ld_req || ld_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid <= 1'b0;
         cmd_owner <= OWNER_CPU;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else begin
         cmd_valid <= cpu_gnt | ld_gnt;
         if (ld_gnt) begin
            cmd_owner <= OWNER_LD;
            cmd_we    <= ld_we;
            cmd_addr  <= ld_addr;
            cmd_wdata <= ld_wdata;
         end else if (cpu_gnt) begin
            cmd_owner <= OWNER_CPU;
            cmd_we    <= cpu_we;
            cmd_addr  <= cpu_addr;
            cmd_wdata <= cpu_wdata;
         end
      end
   end

   // A write pending in the command register is dropped by reset because cmd_valid clears asynchronously.
   assign mem_addr  = cmd_addr;
   assign mem_wdata = cmd_wdata;
   assign mem_we    = cmd_valid & cmd_we;
   assign read_done = cmd_valid & ~cmd_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rvalid <= 1'b0;
         ld_rvalid  <= 1'b0;
         cpu_rdata  <= '0;
         ld_rdata   <= '0;
      end else begin
         cpu_rvalid <= read_done & (cmd_owner == OWNER_CPU);
         ld_rvalid  <= read_done & (cmd_owner == OWNER_LD);
         if (read_done && cmd_owner == OWNER_CPU) begin
            cpu_rdata <= mem_rdata;
         end
         if (read_done && cmd_owner == OWNER_LD) begin
            ld_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus constrained-random traffic
// checked against a queue-based reference of grants, memory contents and responses.
module tb_dmem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_gnt, cpu_stall, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          ld_req = 1'b0, ld_we = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_wdata = '0;
   logic          ld_gnt, ld_rvalid;
   logic [DW-1:0] ld_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   dmem_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Sixteen-word data memory: combinational read, write on the rising edge.
   logic [DW-1:0] mem [0:15];
   assign mem_rdata = mem[mem_addr[5:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;

   // Reference model: expected memory image, queued read responses and a denial counter.
   typedef struct { int due; bit to_ld; logic [DW-1:0] data; } resp_t;
   resp_t         rq[$];
   logic [DW-1:0] ref_mem [0:15];
   int            cyc = 0;
   int            m_starve = 0;
   bit            pw_valid = 0;
   logic [AW-1:0] pw_addr;
   logic [DW-1:0] pw_data;
   bit            e_cmd_valid = 0, e_cmd_we = 0;
   logic [AW-1:0] e_cmd_addr = '0;
   logic [DW-1:0] e_cmd_wdata = '0;
   logic [DW-1:0] e_cpu_rd = '0, e_ld_rd = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      rq.delete();
      pw_valid    = 0;
      m_starve    = 0;
      e_cmd_valid = 0;
      e_cmd_we    = 0;
      e_cpu_rd    = '0;
      e_ld_rd     = '0;
   endtask

   // One clock cycle: entered and left 1 time unit after a rising edge.
   task automatic tick(input logic cr, input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic lr, input logic lwe, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       output logic cg, output logic lg);
      bit    e_cg, e_lg, e_cpu_rv, e_ld_rv;
      resp_t r;
      cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
      ld_req  = lr; ld_we  = lwe; ld_addr  = la; ld_wdata  = ld;
      #2;
      e_lg = lr && (!cr || m_starve == SL);
      e_cg = cr && !e_lg;
      cg = cpu_gnt;
      lg = ld_gnt;
      check("cpu_gnt", cpu_gnt, e_cg);
      check("ld_gnt", ld_gnt, e_lg);
      check("cpu_stall", cpu_stall, cr && !e_cg);
      @(posedge clk);
      cyc++;
      e_cpu_rv = 0;
      e_ld_rv  = 0;
      while (rq.size() > 0 && rq[0].due == cyc) begin
         r = rq.pop_front();
         if (r.to_ld) begin e_ld_rv = 1; e_ld_rd = r.data; end
         else begin e_cpu_rv = 1; e_cpu_rd = r.data; end
      end
      if (pw_valid) begin
         ref_mem[pw_addr[5:2]] = pw_data;
         pw_valid = 0;
      end
      e_cmd_valid = e_cg || e_lg;
      e_cmd_we = 0;
      if (e_lg) begin e_cmd_we = lwe; e_cmd_addr = la; e_cmd_wdata = ld; end
      else if (e_cg) begin e_cmd_we = cwe; e_cmd_addr = ca; e_cmd_wdata = cd; end
      if (e_cmd_valid) begin
         if (e_cmd_we) begin
            pw_valid = 1; pw_addr = e_cmd_addr; pw_data = e_cmd_wdata;
         end else begin
            rq.push_back('{due: cyc + 1, to_ld: e_lg, data: ref_mem[e_cmd_addr[5:2]]});
         end
      end
      m_starve = (!lr || e_lg) ? 0 : ((m_starve < SL) ? m_starve + 1 : SL);
      #1;
      check("cpu_rvalid", cpu_rvalid, e_cpu_rv);
      check("ld_rvalid", ld_rvalid, e_ld_rv);
      check("cpu_rdata", cpu_rdata, e_cpu_rd);
      check("ld_rdata", ld_rdata, e_ld_rd);
      check("mem_we", mem_we, e_cmd_valid && e_cmd_we);
      if (e_cmd_valid) check("mem_addr", mem_addr, e_cmd_addr);
      if (e_cmd_valid && e_cmd_we) check("mem_wdata", mem_wdata, e_cmd_wdata);
   endtask

   task automatic idle(input int n);
      logic cg, lg;
      for (int i = 0; i < n; i++) tick(0, 0, '0, '0, 0, 0, '0, '0, cg, lg);
   endtask

   initial begin
      logic          cg, lg, ld_rv_seen, c_pend, l_pend, cr, cwe, lr, lwe;
      logic [AW-1:0] ca, la;
      logic [DW-1:0] cd, ld, old_val;

      for (int i = 0; i < 16; i++) begin
         logic [DW-1:0] v;
         v = $urandom;
         mem[i] <= v;
         ref_mem[i] = v;
      end

      // Reset held with both requesters active.
      #1;
      rst_n = 1'b0;
      cpu_req = 1'b1; ld_req = 1'b1; cpu_addr = 32'h4; ld_addr = 32'h8;
      #1;
      check("rst_cpu_gnt", cpu_gnt, 0);
      check("rst_ld_gnt", ld_gnt, 0);
      check("rst_cpu_stall", cpu_stall, 1);
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_ld_rvalid", ld_rvalid, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_ld_rdata", ld_rdata, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      @(posedge clk);
      #1;
      check("rst_edge_mem_we", mem_we, 0);
      rst_n = 1'b1;
      tick(1, 0, 32'h4, '0, 1, 0, 32'h8, '0, cg, lg);
      check("first_grant_cpu", cg, 1);
      idle(3);

      // CPU read alone.
      mem[4] <= 32'hDEADBEEF;
      ref_mem[4] = 32'hDEADBEEF;
      tick(1, 0, 32'h10, '0, 0, 0, '0, '0, cg, lg);
      check("read_gnt_same_cycle", cg, 1);
      check("read_mem_addr", mem_addr, 32'h10);
      idle(1);
      check("read_rvalid", cpu_rvalid, 1);
      check("read_rdata", cpu_rdata, 32'hDEADBEEF);
      check("read_no_ld_rvalid", ld_rvalid, 0);
      idle(1);
      check("read_rvalid_one_cycle", cpu_rvalid, 0);

      // Continuous contention: four CPU grants then one loader grant, repeating.
      for (int i = 0; i < 10; i++) begin
         tick(1, 0, 32'h4, '0, 1, 0, 32'h8, '0, cg, lg);
         check("cont_ld_gnt", lg, (i % 5) == 4);
         check("cont_cpu_gnt", cg, (i % 5) != 4);
      end
      idle(3);

      // Loader write followed immediately by a CPU read of the same word.
      ld_rv_seen = 0;
      tick(0, 0, '0, '0, 1, 1, 32'h20, 32'h12345678, cg, lg);
      ld_rv_seen |= ld_rvalid;
      tick(1, 0, 32'h20, '0, 0, 0, '0, '0, cg, lg);
      ld_rv_seen |= ld_rvalid;
      idle(1);
      ld_rv_seen |= ld_rvalid;
      check("wr_rd_rvalid", cpu_rvalid, 1);
      check("wr_rd_rdata", cpu_rdata, 32'h12345678);
      idle(1);
      ld_rv_seen |= ld_rvalid;
      check("wr_no_ld_rvalid", ld_rv_seen, 0);

      // Reset arriving while a loader write sits in the command register.
      old_val = ref_mem[12];
      tick(0, 0, '0, '0, 1, 1, 32'h30, ~old_val, cg, lg);
      check("midwr_mem_we_before", mem_we, 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midwr_mem_we_drop", mem_we, 0);
      ld_req = 1'b0;
      @(posedge clk);
      #1;
      check("midwr_mem_kept", mem[12], old_val);
      rst_n = 1'b1;
      idle(2);

      // Loader alone with an intermittent request, then contention still yields 4 CPU grants first.
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, '0, '0, (i != 1), 0, 32'h8, '0, cg, lg);
         check("ld_alone_gnt", lg, i != 1);
      end
      for (int i = 0; i < 5; i++) begin
         tick(1, 0, 32'h4, '0, 1, 0, 32'h8, '0, cg, lg);
         check("post_ld_cont", lg, i == 4);
      end
      idle(3);

      // Random traffic; a denied requester either holds its fields or drops the request.
      c_pend = 0; l_pend = 0;
      cr = 0; cwe = 0; ca = '0; cd = '0; lr = 0; lwe = 0; la = '0; ld = '0;
      for (int i = 0; i < 2000; i++) begin
         if (!(c_pend && $urandom_range(7) != 0)) begin
            cr  = ($urandom_range(3) != 0);
            cwe = $urandom_range(1);
            ca  = AW'($urandom_range(15)) << 2;
            cd  = $urandom;
         end
         if (!(l_pend && $urandom_range(7) != 0)) begin
            lr  = $urandom_range(1);
            lwe = $urandom_range(1);
            la  = AW'($urandom_range(15)) << 2;
            ld  = $urandom;
         end
         tick(cr, cwe, ca, cd, lr, lwe, la, ld, cg, lg);
         c_pend = cr && !cg;
         l_pend = lr && !lg;
      end
      idle(3);
      for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
